// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: jump redirect/flush,
// load-use bubbles and data-RAM wait stalls with a sticky timeout flag.
module pipe_ctrl #(
  parameter int MEM_ADDR_W   = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                  clk_100M,
  input  logic                  arst_n,
  input  logic                  jump_flag_i,
  input  logic [MEM_ADDR_W-1:0] jump_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs1_ena_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_ena_i,
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ram_busy_i,
  output logic                  pc_hold_o,
  output logic                  pc_jump_ena_o,
  output logic [MEM_ADDR_W-1:0] pc_jump_addr_o,
  output logic                  if_id_hold_o,
  output logic                  if_id_clear_o,
  output logic                  id_ex_hold_o,
  output logic                  id_ex_clear_o,
  output logic                  ex_mem_hold_o,
  output logic                  ex_mem_clear_o,
  output logic                  mem_wb_hold_o,
  output logic                  mem_wb_clear_o,
  output logic                  timeout_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD  = FW'(FLUSH_CYCLES - 1);
  localparam logic [7:0]    TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_cnt_next;
  logic [7:0]    wait_cnt;
  logic [7:0]    wait_cnt_next;
  logic [7:0]    wait_cnt_inc;
  logic          timeout_next;
  logic          load_use;

  assign wait_cnt_inc = (wait_cnt == 8'hFF) ? 8'hFF : (wait_cnt + 8'd1);

  assign load_use = ex_load_i && (ex_rd_addr_i != {REG_ADDR_W{1'b0}}) &&
                    ((id_rs1_ena_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_ena_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Control outputs and next state; priority is reset > busy > jump > load-use.
  always_comb begin
    pc_hold_o      = 1'b0;
    pc_jump_ena_o  = 1'b0;
    pc_jump_addr_o = {MEM_ADDR_W{1'b0}};
    if_id_hold_o   = 1'b0;
    if_id_clear_o  = 1'b0;
    id_ex_hold_o   = 1'b0;
    id_ex_clear_o  = 1'b0;
    ex_mem_hold_o  = 1'b0;
    ex_mem_clear_o = 1'b0;
    mem_wb_hold_o  = 1'b0;
    mem_wb_clear_o = 1'b0;
    state_next     = state;
    flush_cnt_next = flush_cnt;
    wait_cnt_next  = 8'd0;
    timeout_next   = timeout_o;

    if (!arst_n) begin
      if_id_clear_o  = 1'b1;
      id_ex_clear_o  = 1'b1;
      ex_mem_clear_o = 1'b1;
      mem_wb_clear_o = 1'b1;
      state_next     = S_IDLE;
      flush_cnt_next = {FW{1'b0}};
      timeout_next   = 1'b0;
    end else if (ram_busy_i) begin
      // Freeze everything upstream; bubble writeback so it is not repeated.
      pc_hold_o      = 1'b1;
      if_id_hold_o   = 1'b1;
      id_ex_hold_o   = 1'b1;
      ex_mem_hold_o  = 1'b1;
      mem_wb_clear_o = 1'b1;
      wait_cnt_next  = wait_cnt_inc;
      if (wait_cnt_inc >= TIMEOUT_CNT) begin
        timeout_next = 1'b1;
      end else begin
        timeout_next = timeout_o;
      end
      if (state == S_FLUSH) begin
        state_next = S_FLUSH;
      end else begin
        state_next = S_WAIT;
      end
    end else begin
      case (state)
        S_FLUSH: begin
          if_id_clear_o = 1'b1;
          if (flush_cnt <= FW'(1)) begin
            state_next     = S_IDLE;
            flush_cnt_next = {FW{1'b0}};
          end else begin
            flush_cnt_next = flush_cnt - FW'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
          if (jump_flag_i) begin
            pc_jump_ena_o  = 1'b1;
            pc_jump_addr_o = jump_addr_i;
            if_id_clear_o  = 1'b1;
            id_ex_clear_o  = 1'b1;
            ex_mem_clear_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next     = S_FLUSH;
              flush_cnt_next = FLUSH_LOAD;
            end else begin
              state_next     = S_IDLE;
            end
          end else if (load_use) begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_clear_o = 1'b1;
          end else begin
            pc_hold_o     = 1'b0;
          end
        end
      endcase
    end
  end

  // State, counters and sticky timeout, with synchronous active-low reset.
  always_ff @(posedge clk_100M) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      flush_cnt <= {FW{1'b0}};
      wait_cnt  <= 8'd0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      wait_cnt  <= wait_cnt_next;
      timeout_o <= timeout_next;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// compared against a cycle-level reference model of the control rules.
module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int RW = 5;
  localparam int FC = 2;
  localparam int WT = 4;

  logic          clk_100M = 1'b0;
  logic          arst_n;
  logic          jump_flag_i;
  logic [AW-1:0] jump_addr_i;
  logic [RW-1:0] id_rs1_addr_i;
  logic          id_rs1_ena_i;
  logic [RW-1:0] id_rs2_addr_i;
  logic          id_rs2_ena_i;
  logic          ex_load_i;
  logic [RW-1:0] ex_rd_addr_i;
  logic          ram_busy_i;
  logic          pc_hold_o;
  logic          pc_jump_ena_o;
  logic [AW-1:0] pc_jump_addr_o;
  logic          if_id_hold_o, if_id_clear_o;
  logic          id_ex_hold_o, id_ex_clear_o;
  logic          ex_mem_hold_o, ex_mem_clear_o;
  logic          mem_wb_hold_o, mem_wb_clear_o;
  logic          timeout_o;

  int   checks = 0;
  int   errors = 0;
  // Reference model: remaining flush cycles, consecutive busy cycles, sticky flag.
  int   flush_left = 0;
  int   busy_run = 0;
  logic to_m = 1'b0;

  always #5 clk_100M = ~clk_100M;

  pipe_ctrl #(
    .MEM_ADDR_W(AW), .REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .WAIT_TIMEOUT(WT)
  ) dut (
    .clk_100M(clk_100M), .arst_n(arst_n),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_ena_i(id_rs1_ena_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_ena_i(id_rs2_ena_i),
    .ex_load_i(ex_load_i), .ex_rd_addr_i(ex_rd_addr_i), .ram_busy_i(ram_busy_i),
    .pc_hold_o(pc_hold_o), .pc_jump_ena_o(pc_jump_ena_o), .pc_jump_addr_o(pc_jump_addr_o),
    .if_id_hold_o(if_id_hold_o), .if_id_clear_o(if_id_clear_o),
    .id_ex_hold_o(id_ex_hold_o), .id_ex_clear_o(id_ex_clear_o),
    .ex_mem_hold_o(ex_mem_hold_o), .ex_mem_clear_o(ex_mem_clear_o),
    .mem_wb_hold_o(mem_wb_hold_o), .mem_wb_clear_o(mem_wb_clear_o),
    .timeout_o(timeout_o)
  );

  task automatic idle_inputs();
    arst_n = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0;
    id_rs1_addr_i = '0; id_rs1_ena_i = 1'b0; id_rs2_addr_i = '0; id_rs2_ena_i = 1'b0;
    ex_load_i = 1'b0; ex_rd_addr_i = '0; ram_busy_i = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied: check, advance model, wait one cycle.
  task automatic cyc(input string tag);
    logic [42:0] obs, expv;
    logic hz;
    logic e_pch, e_je, e_ifh, e_ifc, e_idh, e_idc, e_exh, e_exc, e_mwh, e_mwc;
    logic [AW-1:0] e_ja;
    #1;
    hz = ex_load_i && (ex_rd_addr_i != 5'd0) &&
         ((id_rs1_ena_i && id_rs1_addr_i == ex_rd_addr_i) ||
          (id_rs2_ena_i && id_rs2_addr_i == ex_rd_addr_i));
    {e_pch, e_je, e_ifh, e_ifc, e_idh, e_idc, e_exh, e_exc, e_mwh, e_mwc} = 10'd0;
    e_ja = '0;
    if (!arst_n) begin
      {e_ifc, e_idc, e_exc, e_mwc} = 4'hF;
    end else if (ram_busy_i) begin
      {e_pch, e_ifh, e_idh, e_exh, e_mwc} = 5'h1F;
    end else if (flush_left > 0) begin
      e_ifc = 1'b1;
    end else if (jump_flag_i) begin
      e_je = 1'b1; e_ja = jump_addr_i;
      {e_ifc, e_idc, e_exc} = 3'h7;
    end else if (hz) begin
      {e_pch, e_ifh, e_idc} = 3'h7;
    end
    expv = {e_pch, e_je, e_ja, e_ifh, e_ifc, e_idh, e_idc, e_exh, e_exc, e_mwh, e_mwc, to_m};
    obs  = {pc_hold_o, pc_jump_ena_o, pc_jump_addr_o, if_id_hold_o, if_id_clear_o,
            id_ex_hold_o, id_ex_clear_o, ex_mem_hold_o, ex_mem_clear_o,
            mem_wb_hold_o, mem_wb_clear_o, timeout_o};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
    if (!arst_n) begin
      flush_left = 0; busy_run = 0; to_m = 1'b0;
    end else if (ram_busy_i) begin
      busy_run = (busy_run >= 255) ? 255 : busy_run + 1;
      if (busy_run >= WT) to_m = 1'b1;
    end else begin
      busy_run = 0;
      if (flush_left > 0) flush_left--;
      else if (jump_flag_i) flush_left = FC - 1;
    end
    @(negedge clk_100M);
  endtask

  initial begin
    idle_inputs();
    arst_n = 1'b0; ram_busy_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h0000_1234;
    @(posedge clk_100M);
    @(negedge clk_100M);
    cyc("reset_0");
    cyc("reset_1");
    idle_inputs();
    cyc("after_reset_idle");

    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0040;
    cyc("jump_redirect");
    jump_flag_i = 1'b0; jump_addr_i = '0;
    cyc("jump_flush");
    cyc("jump_done");

    ex_load_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs2_ena_i = 1'b1; id_rs2_addr_i = 5'd5;
    cyc("load_use_rs2");
    idle_inputs();
    cyc("load_use_resolved");
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd0; id_rs1_ena_i = 1'b1; id_rs1_addr_i = 5'd0;
    id_rs2_ena_i = 1'b1; id_rs2_addr_i = 5'd0;
    cyc("load_use_rd0");
    idle_inputs();

    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0080; ram_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc("busy_jump_stall");
    ram_busy_i = 1'b0;
    cyc("busy_jump_release");
    jump_flag_i = 1'b0;
    cyc("busy_jump_flush");
    cyc("busy_jump_done");

    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
    cyc("flush_busy_jump");
    jump_flag_i = 1'b0; ram_busy_i = 1'b1;
    cyc("flush_frozen_by_busy");
    ram_busy_i = 1'b0;
    cyc("flush_resumes");
    cyc("flush_over");

    ram_busy_i = 1'b1;
    for (int i = 0; i < 6; i++) cyc("timeout_busy");
    ram_busy_i = 1'b0;
    cyc("timeout_sticky_0");
    cyc("timeout_sticky_1");
    arst_n = 1'b0;
    cyc("timeout_reset");
    arst_n = 1'b1;
    cyc("timeout_cleared");

    for (int n = 0; n < 600; n++) begin
      arst_n        = ($urandom_range(0, 49) != 0);
      ram_busy_i    = ($urandom_range(0, 3) == 0);
      jump_flag_i   = ($urandom_range(0, 5) == 0);
      jump_addr_i   = $urandom;
      id_rs1_addr_i = RW'($urandom_range(0, 3));
      id_rs2_addr_i = RW'($urandom_range(0, 3));
      ex_rd_addr_i  = RW'($urandom_range(0, 3));
      id_rs1_ena_i  = 1'($urandom);
      id_rs2_ena_i  = 1'($urandom);
      ex_load_i     = 1'($urandom);
      cyc("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
